// File: rtl/ps2_tx.sv
// ps2_tx: PS/2 host-to-device command transmitter.
// Sends one byte with odd parity and reports device ack, nack or timeout.
module ps2_tx #(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int INHIBIT_CYC = 5_000,
    parameter int TIMEOUT_CYC = 100_000
) (
    input  logic       mclk,
    input  logic       reset,
    inout  wire        PS2C,
    inout  wire        PS2D,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       tx_err_tick
);

    // Cycle counter is shared by the inhibit timer and the watchdog; it is
    // also kept wide enough to hold a standard 2 ms interval at CLK_FREQ.
    localparam int TWO_MS = CLK_FREQ / 500;
    localparam int M1     = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
    localparam int MAXC   = (M1 > TWO_MS) ? M1 : TWO_MS;
    localparam int CW     = $clog2(MAXC + 1);

    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYC - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE, RTS, START, DATA, STOP, ACK, WAIT_REL
    } state_t;

    state_t        state, state_n;
    logic [8:0]    shift, shift_n;
    logic [3:0]    cnt, cnt_n;
    logic [CW-1:0] cyc, cyc_n;
    logic          ok, ok_n;
    logic          c_en, d_en, c_en_n, d_en_n;

    logic [7:0]    flt_sr;
    logic          c_filt;
    logic          d_meta, d_sync;

    logic          fall_edge;
    logic          wd_on;
    logic          rel_ev;
    logic          tmo;

    // Never drive a 1: pull low or float.
    assign PS2C = c_en ? 1'b0 : 1'bz;
    assign PS2D = d_en ? 1'b0 : 1'bz;

    // Debounce the device clock: only 8 equal samples change the filtered level.
    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            flt_sr <= '1;
            c_filt <= 1'b1;
        end else begin
            flt_sr <= {flt_sr[6:0], PS2C};
            if (flt_sr == 8'hFF)
                c_filt <= 1'b1;
            else if (flt_sr == 8'h00)
                c_filt <= 1'b0;
        end
    end

    // Two-flop synchronizer for the data line.
    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            d_meta <= 1'b1;
            d_sync <= 1'b1;
        end else begin
            d_meta <= PS2D;
            d_sync <= d_meta;
        end
    end

    assign fall_edge = c_filt && (flt_sr == 8'h00);
    assign wd_on     = (state != IDLE) && (state != RTS);
    assign rel_ev    = (state == WAIT_REL) && c_filt && d_sync;
    assign tmo       = wd_on && !fall_edge && !rel_ev && (cyc == TMO_LAST);

    // State, datapath and registered line enables.
    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            shift <= '0;
            cnt   <= '0;
            cyc   <= '0;
            ok    <= 1'b0;
            c_en  <= 1'b0;
            d_en  <= 1'b0;
        end else begin
            state <= state_n;
            shift <= shift_n;
            cnt   <= cnt_n;
            cyc   <= cyc_n;
            ok    <= ok_n;
            c_en  <= c_en_n;
            d_en  <= d_en_n;
        end
    end

    // Next-state and datapath updates; watchdog overrides everything.
    always_comb begin
        state_n = state;
        shift_n = shift;
        cnt_n   = cnt;
        ok_n    = ok;
        cyc_n   = cyc + CW'(1);
        unique case (state)
            IDLE: begin
                cyc_n = '0;
                if (wr_ps2) begin
                    shift_n = {~^din, din};
                    state_n = RTS;
                end
            end
            RTS: begin
                if (cyc == INH_LAST) begin
                    state_n = START;
                    cyc_n   = '0;
                end
            end
            START: begin
                if (fall_edge) begin
                    state_n = DATA;
                    cnt_n   = '0;
                end
            end
            DATA: begin
                if (fall_edge) begin
                    if (cnt == 4'd8) begin
                        state_n = STOP;
                    end else begin
                        shift_n = {1'b0, shift[8:1]};
                        cnt_n   = cnt + 4'd1;
                    end
                end
            end
            STOP: begin
                if (fall_edge)
                    state_n = ACK;
            end
            ACK: begin
                if (fall_edge) begin
                    ok_n    = ~d_sync;
                    state_n = WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (rel_ev)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (wd_on && fall_edge)
            cyc_n = '0;
        if (tmo) begin
            state_n = IDLE;
            cyc_n   = '0;
        end
    end

    // Line enables follow the next state; status flags follow the current one.
    always_comb begin
        c_en_n       = 1'b0;
        d_en_n       = 1'b0;
        unique case (state_n)
            RTS:     c_en_n = 1'b1;
            START:   d_en_n = 1'b1;
            DATA:    d_en_n = ~shift_n[0];
            default: ;
        endcase
        tx_idle      = (state == IDLE);
        tx_done_tick = rel_ev && ok;
        tx_err_tick  = tmo || (rel_ev && !ok);
    end

endmodule

// File: tb/tb_ps2_tx.sv
// tb_ps2_tx: directed bench for ps2_tx with a simple PS/2 device model.
// Device clocks the frame, captures start/data/parity/stop and answers ack.
module tb_ps2_tx;

    localparam int INH  = 300;
    localparam int TMO  = 3000;
    localparam int HALF = 20;

    logic       mclk   = 1'b0;
    logic       reset  = 1'b0;
    logic       wr_ps2 = 1'b0;
    logic [7:0] din    = 8'h00;
    logic       tx_idle, tx_done_tick, tx_err_tick;

    wire  ps2c, ps2d;
    logic dev_c = 1'b0;
    logic dev_d = 1'b0;

    assign ps2c = dev_c ? 1'b0 : 1'bz;
    assign ps2d = dev_d ? 1'b0 : 1'bz;
    pullup (ps2c);
    pullup (ps2d);

    int checks = 0;
    int errors = 0;
    int both   = 0;

    ps2_tx #(
        .CLK_FREQ   (50_000_000),
        .INHIBIT_CYC(INH),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .mclk        (mclk),
        .reset       (reset),
        .PS2C        (ps2c),
        .PS2D        (ps2d),
        .wr_ps2      (wr_ps2),
        .din         (din),
        .tx_idle     (tx_idle),
        .tx_done_tick(tx_done_tick),
        .tx_err_tick (tx_err_tick)
    );

    always #5 mclk = ~mclk;

    // Done and error must never coincide.
    always @(negedge mclk)
        if (reset && tx_done_tick && tx_err_tick) both++;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge mclk);
        #1 din = b;
        wr_ps2 = 1'b1;
        @(posedge mclk);
        #1 wr_ps2 = 1'b0;
    endtask

    task automatic wait_start(output logic seen);
        seen = 1'b0;
        for (int k = 0; k < INH + 200; k++) begin
            @(negedge mclk);
            if (ps2c === 1'b1 && ps2d === 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic dev_pulse(output logic b);
        repeat (HALF) @(posedge mclk);
        #1 b = ps2d;
        dev_c = 1'b1;
        repeat (HALF) @(posedge mclk);
        #1 dev_c = 1'b0;
    endtask

    task automatic run_frame(input logic ack, input int wr_at,
                             output logic [10:0] fr);
        logic s;
        logic seen;
        fr = '0;
        wait_start(seen);
        check("start_seen", {31'd0, seen}, 32'd1);
        if (seen) begin
            repeat (30) @(posedge mclk);
            for (int i = 0; i < 11; i++) begin
                dev_pulse(s);
                fr[i] = s;
                if (i == wr_at) begin
                    din    = 8'hFF;
                    wr_ps2 = 1'b1;
                    @(posedge mclk);
                    #1 wr_ps2 = 1'b0;
                end
            end
            dev_d = ack;
            dev_pulse(s);
            dev_d = 1'b0;
        end
    endtask

    task automatic collect(output int nd, output int ne);
        nd = 0;
        ne = 0;
        repeat (150) begin
            @(negedge mclk);
            if (tx_done_tick) nd++;
            if (tx_err_tick)  ne++;
        end
    endtask

    initial begin
        logic [10:0] fr;
        int          nd, ne, n, lows;
        logic        s;
        logic        seen;

        // Reset state
        repeat (2) @(negedge mclk);
        check("rst_c", {31'd0, ps2c}, 32'd1);
        check("rst_d", {31'd0, ps2d}, 32'd1);
        check("rst_idle", {31'd0, tx_idle}, 32'd1);
        check("rst_done", {31'd0, tx_done_tick}, 32'd0);
        check("rst_err", {31'd0, tx_err_tick}, 32'd0);
        @(posedge mclk);
        #1 reset = 1'b1;
        repeat (20) @(posedge mclk);

        // 0xED acked
        send(8'hED);
        n = 0;
        for (int k = 0; k < INH + 100; k++) begin
            @(negedge mclk);
            if (k == 0) begin
                check("rts_idle", {31'd0, tx_idle}, 32'd0);
                check("rts_d_rel", {31'd0, ps2d}, 32'd1);
            end
            if (ps2c !== 1'b0) break;
            n++;
        end
        check("inhibit_len", n, INH);
        run_frame(1'b1, -1, fr);
        check("frame_ED", {21'd0, fr}, 32'h7DA);
        collect(nd, ne);
        check("ED_done", nd, 1);
        check("ED_err", ne, 0);
        check("ED_idle", {31'd0, tx_idle}, 32'd1);

        // 0xF4 acked, parity 0
        send(8'hF4);
        run_frame(1'b1, -1, fr);
        check("frame_F4", {21'd0, fr}, 32'h5E8);
        check("F4_par", {31'd0, fr[9]}, 32'd0);
        collect(nd, ne);
        check("F4_done", nd, 1);
        check("F4_err", ne, 0);

        // 0x00 nacked
        send(8'h00);
        run_frame(1'b0, -1, fr);
        check("frame_00", {21'd0, fr}, 32'h600);
        collect(nd, ne);
        check("nack_done", nd, 0);
        check("nack_err", ne, 1);

        // Device stops clocking after 3 edges
        send(8'h00);
        wait_start(seen);
        check("to_start", {31'd0, seen}, 32'd1);
        repeat (30) @(posedge mclk);
        dev_pulse(s);
        dev_pulse(s);
        repeat (HALF) @(posedge mclk);
        #1 dev_c = 1'b1;
        n  = 0;
        nd = 0;
        for (int k = 0; k < TMO + 100; k++) begin
            @(negedge mclk);
            n++;
            if (n == HALF) dev_c = 1'b0;
            if (tx_done_tick) nd++;
            if (tx_err_tick) break;
        end
        check("to_delay", n, TMO + 9);
        check("to_nodone", nd, 0);
        @(negedge mclk);
        check("to_pulse1", {31'd0, tx_err_tick}, 32'd0);
        check("to_c_rel", {31'd0, ps2c}, 32'd1);
        check("to_d_rel", {31'd0, ps2d}, 32'd1);
        check("to_idle", {31'd0, tx_idle}, 32'd1);
        repeat (20) @(posedge mclk);

        // Second request during DATA is ignored
        send(8'hED);
        run_frame(1'b1, 4, fr);
        check("wr_frame", {21'd0, fr}, 32'h7DA);
        collect(nd, ne);
        check("wr_done", nd, 1);
        check("wr_err", ne, 0);
        lows = 0;
        repeat (100) begin
            @(negedge mclk);
            if (ps2c === 1'b0) lows++;
        end
        check("wr_noqueue", lows, 0);

        // Reset during DATA
        send(8'h00);
        wait_start(seen);
        check("rs_start", {31'd0, seen}, 32'd1);
        repeat (30) @(posedge mclk);
        dev_pulse(s);
        dev_pulse(s);
        repeat (5) @(posedge mclk);
        #1 check("rs_d_low", {31'd0, ps2d}, 32'd0);
        reset = 1'b0;
        #1;
        check("rs_d_rel", {31'd0, ps2d}, 32'd1);
        check("rs_c_rel", {31'd0, ps2c}, 32'd1);
        check("rs_idle", {31'd0, tx_idle}, 32'd1);
        @(posedge mclk);
        #1 reset = 1'b1;
        collect(nd, ne);
        check("rs_done", nd, 0);
        check("rs_err", ne, 0);
        check("no_both", both, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
